// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: self-timed oversampling, 3-sample majority vote,
// optional parity, 1-2 stop bits, one-deep holding register with ack and error flags.
module uart_rx_param #(
    parameter int CLK_DIV    = 27,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 i_Clk,
    input  logic                 i_rst,
    input  logic                 i_En,
    input  logic                 i_Rx,
    input  logic                 i_Ack,
    output logic [DATA_BITS-1:0] o_Data,
    output logic                 o_Valid,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Overrun,
    output logic                 o_Busy
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS) + 1;
    localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [TW-1:0] T_LAST    = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] T_S0      = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_S1      = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_S2      = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT_IDLE
    } state_t;

    state_t                 state;
    logic                   rx_meta, rx_s;
    logic [CW-1:0]          div_cnt;
    logic [TW-1:0]          t;
    logic [BW-1:0]          bit_cnt;
    logic [1:0]             smp;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_err, frame_err;
    logic                   tick, decide, bit_end, maj, par_bad, stop_err;

    assign tick     = (state != S_IDLE) && (div_cnt == DIV_LAST);
    assign decide   = tick && (t == T_S2);
    assign bit_end  = tick && (t == T_LAST);
    // third sample is the live synchronised value at the decision tick
    assign maj      = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);
    assign par_bad  = (^shreg) ^ maj ^ (PARITY == 1);
    assign stop_err = frame_err | ~maj;
    assign o_Busy   = (state != S_IDLE);

    always_ff @(posedge i_Clk or negedge i_rst) begin
        if (!i_rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_Rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_Clk or negedge i_rst) begin
        if (!i_rst) begin
            state        <= S_IDLE;
            div_cnt      <= '0;
            t            <= '0;
            bit_cnt      <= '0;
            smp          <= '0;
            shreg        <= '0;
            par_err      <= 1'b0;
            frame_err    <= 1'b0;
            o_Data       <= '0;
            o_Valid      <= 1'b0;
            o_Parity_Err <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Overrun    <= 1'b0;
        end else begin
            if (i_Ack && o_Valid) begin
                o_Valid      <= 1'b0;
                o_Parity_Err <= 1'b0;
                o_Frame_Err  <= 1'b0;
                o_Overrun    <= 1'b0;
            end

            if (state != S_IDLE) begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
                if (tick) begin
                    t <= (t == T_LAST) ? '0 : t + 1'b1;
                    if (t == T_S0) smp[0] <= rx_s;
                    if (t == T_S1) smp[1] <= rx_s;
                end
            end

            if (!i_En && state != S_IDLE) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: if (i_En && !rx_s) begin
                        state     <= S_START;
                        div_cnt   <= '0;
                        t         <= '0;
                        bit_cnt   <= '0;
                        par_err   <= 1'b0;
                        frame_err <= 1'b0;
                    end
                    S_START: begin
                        if (decide && maj)  state <= S_IDLE;
                        else if (bit_end)   state <= S_DATA;
                    end
                    S_DATA: begin
                        if (decide) shreg <= {maj, shreg[DATA_BITS-1:1]};
                        if (bit_end) begin
                            if (bit_cnt == DATA_LAST) begin
                                bit_cnt <= '0;
                                state   <= (PARITY != 0) ? S_PAR : S_STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    S_PAR: begin
                        if (decide)  par_err <= par_bad;
                        if (bit_end) state   <= S_STOP;
                    end
                    S_STOP: begin
                        if (decide) begin
                            frame_err <= stop_err;
                            // publish on the final stop decision, without waiting for bit end
                            if (bit_cnt == STOP_LAST) begin
                                o_Data       <= shreg;
                                o_Parity_Err <= par_err;
                                o_Frame_Err  <= stop_err;
                                o_Valid      <= 1'b1;
                                if (o_Valid && !i_Ack) o_Overrun <= 1'b1;
                                state <= stop_err ? S_WAIT_IDLE : S_IDLE;
                            end
                        end else if (bit_end) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    S_WAIT_IDLE: if (rx_s) state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: two instances (8N1 and 8E2) driven with directed and random
// frames; a frame-level model fills per-instance queues that a negedge monitor drains.
module tb_uart_rx_param;

    localparam int CLK_DIV = 4;
    localparam int OS      = 16;
    localparam int BIT     = CLK_DIV * OS;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       ov;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rx[2], en[2], ack[2];
    logic [7:0] dout[2];
    logic       vld[2], pe[2], fe[2], ov[2], busy[2];

    exp_t        q0[$], q1[$];
    logic        held[2], ovr_m[2];
    int unsigned vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    uart_rx_param #(.CLK_DIV(CLK_DIV), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
        .i_Clk(clk), .i_rst(rst_n), .i_En(en[0]), .i_Rx(rx[0]), .i_Ack(ack[0]),
        .o_Data(dout[0]), .o_Valid(vld[0]), .o_Parity_Err(pe[0]), .o_Frame_Err(fe[0]),
        .o_Overrun(ov[0]), .o_Busy(busy[0]));

    uart_rx_param #(.CLK_DIV(CLK_DIV), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dut1 (
        .i_Clk(clk), .i_rst(rst_n), .i_En(en[1]), .i_Rx(rx[1]), .i_Ack(ack[1]),
        .o_Data(dout[1]), .o_Valid(vld[1]), .o_Parity_Err(pe[1]), .o_Frame_Err(fe[1]),
        .o_Overrun(ov[1]), .o_Busy(busy[1]));

    task automatic chk(input string nm, input int act, input int exp_v);
        vectors++;
        if (act != exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic cmp_out(input int i, input logic [10:0] k);
        exp_t e;
        int   n;
        n = (i == 0) ? q0.size() : q1.size();
        if (n == 0) begin
            chk($sformatf("dut%0d_unexpected_publish", i), 1, 0);
        end else begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("dut%0d_data", i),   int'(k[10:3]), int'(e.d));
            chk($sformatf("dut%0d_parity", i), int'(k[2]),    int'(e.pe));
            chk($sformatf("dut%0d_frame", i),  int'(k[1]),    int'(e.fe));
            chk($sformatf("dut%0d_overrun", i), int'(k[0]),   int'(e.ov));
        end
    endtask

    // Monitor: a publish shows as o_Valid rising or the held word/flags changing while valid.
    logic       pv[2];
    logic [10:0] pk[2];
    initial begin
        pv[0] = 1'b0; pv[1] = 1'b0; pk[0] = '0; pk[1] = '0;
    end
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [10:0] k;
            k = {dout[i], pe[i], fe[i], ov[i]};
            if (rst_n && vld[i] && (!pv[i] || k != pk[i])) cmp_out(i, k);
            pv[i] = vld[i];
            pk[i] = k;
        end
    end

    // Frame-level model: expected result follows from the bits on the wire and the holding state.
    task automatic send_frame(input int i, input logic [7:0] d, input logic p,
                              input logic [1:0] sv, input int brk, input int gap);
        exp_t e;
        logic bits[$];
        int   nstop;
        nstop = (i == 0) ? 1 : 2;
        e.d   = d;
        e.pe  = (i == 1) ? ((($countones(d) + int'(p)) % 2) != 0) : 1'b0;
        e.fe  = (nstop == 1) ? !sv[0] : !(sv[0] && sv[1]);
        e.ov  = ovr_m[i] | held[i];
        ovr_m[i] = e.ov;
        held[i]  = 1'b1;
        if (i == 0) q0.push_back(e); else q1.push_back(e);
        bits.push_back(1'b0);
        for (int b = 0; b < 8; b++) bits.push_back(d[b]);
        if (i == 1) bits.push_back(p);
        bits.push_back(sv[0]);
        if (nstop == 2) bits.push_back(sv[1]);
        for (int b = 0; b < brk; b++) bits.push_back(1'b0);
        for (int b = 0; b < gap; b++) bits.push_back(1'b1);
        @(posedge clk); #1;
        foreach (bits[b]) begin
            rx[i] = bits[b];
            repeat (BIT) @(posedge clk);
            #1;
        end
        rx[i] = 1'b1;
    endtask

    task automatic do_ack(input int i);
        @(posedge clk); #1;
        ack[i] = 1'b1;
        @(posedge clk); #1;
        ack[i] = 1'b0;
        chk($sformatf("dut%0d_ack_clears", i), int'({vld[i], pe[i], fe[i], ov[i]}), 0);
        held[i]  = 1'b0;
        ovr_m[i] = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        for (int i = 0; i < 2; i++) begin
            rx[i] = 1'b1; en[i] = 1'b1; ack[i] = 1'b0; held[i] = 1'b0; ovr_m[i] = 1'b0;
        end
        #2 rst_n = 1'b0;
        wait_cyc(3);
        for (int i = 0; i < 2; i++)
            chk($sformatf("dut%0d_reset_state", i),
                int'({dout[i], vld[i], pe[i], fe[i], ov[i], busy[i]}), 0);
        rst_n = 1'b1;
        wait_cyc(4);

        // 8N1 0xA5 with latency window
        lat = 0;
        fork
            send_frame(0, 8'hA5, 1'b0, 2'b11, 0, 1);
            begin
                @(posedge clk); #1;
                while (!vld[0] && lat < 2000) begin
                    @(posedge clk); #1;
                    lat++;
                end
            end
        join
        chk("dut0_latency_window", int'(lat >= 600 && lat <= 640), 1);
        chk("dut0_busy_after_frame", int'(busy[0]), 0);
        do_ack(0);

        // false start: 10 clocks low
        @(posedge clk); #1;
        rx[0] = 1'b0;
        wait_cyc(10);
        rx[0] = 1'b1;
        wait_cyc(5);
        chk("dut0_busy_in_start", int'(busy[0]), 1);
        wait_cyc(2 * BIT);
        chk("dut0_false_start_idle", int'({vld[0], busy[0]}), 0);

        // even parity: 0x03 with bad then good parity bit
        send_frame(1, 8'h03, 1'b1, 2'b11, 0, 1);
        do_ack(1);
        send_frame(1, 8'h03, 1'b0, 2'b11, 0, 1);
        do_ack(1);

        // break after a 0x00 frame: frame error, held in WAIT_IDLE
        fork
            send_frame(0, 8'h00, 1'b0, 2'b10, 3, 1);
            begin
                wait_cyc(11 * BIT + BIT / 2);
                chk("dut0_busy_during_break", int'(busy[0]), 1);
                chk("dut0_valid_during_break", int'(vld[0]), 1);
            end
        join
        chk("dut0_idle_after_break", int'(busy[0]), 0);
        do_ack(0);

        // back-to-back frames without ack
        send_frame(0, 8'h11, 1'b0, 2'b11, 0, 0);
        send_frame(0, 8'h22, 1'b0, 2'b11, 0, 1);
        do_ack(0);

        // random frames on both instances
        for (int n = 0; n < 10; n++) begin
            logic [7:0] d0, d1;
            logic [1:0] s0, s1;
            d0 = 8'($urandom); d1 = 8'($urandom);
            s0 = ($urandom_range(0, 5) == 0) ? 2'b10 : 2'b11;
            case ($urandom_range(0, 5))
                0: s1 = 2'b10;
                1: s1 = 2'b01;
                default: s1 = 2'b11;
            endcase
            fork
                send_frame(0, d0, 1'b0, s0, 0, 1 + int'($urandom_range(0, 1)));
                send_frame(1, d1, 1'($urandom), s1, 0, 1 + int'($urandom_range(0, 1)));
            join
            for (int i = 0; i < 2; i++)
                if (held[i] && (ovr_m[i] || $urandom_range(0, 1) == 1)) do_ack(i);
        end

        // async reset mid-frame with a word held
        if (held[0]) do_ack(0);
        if (held[1]) do_ack(1);
        send_frame(0, 8'h5A, 1'b0, 2'b11, 0, 1);
        @(posedge clk); #1;
        rx[0] = 1'b0;
        wait_cyc(BIT);
        rx[0] = 1'b1;
        wait_cyc(BIT + BIT / 2);
        chk("dut0_busy_before_reset", int'(busy[0]), 1);
        #3 rst_n = 1'b0;
        #1;
        chk("dut0_async_reset", int'({dout[0], vld[0], pe[0], fe[0], ov[0], busy[0]}), 0);
        held[0] = 1'b0; ovr_m[0] = 1'b0;
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(2 * BIT);

        // enable drop mid-frame
        @(posedge clk); #1;
        rx[0] = 1'b0;
        wait_cyc(2 * BIT + 20);
        chk("dut0_busy_before_en_drop", int'(busy[0]), 1);
        en[0] = 1'b0;
        wait_cyc(1);
        chk("dut0_en_drop_idle", int'(busy[0]), 0);
        rx[0] = 1'b1; wait_cyc(BIT);
        rx[0] = 1'b0; wait_cyc(2 * BIT);
        rx[0] = 1'b1; wait_cyc(3 * BIT);
        en[0] = 1'b1;
        wait_cyc(2 * BIT);
        chk("dut0_no_publish_after_drop", int'(vld[0]), int'(held[0]));

        wait_cyc(10);
        chk("dut0_queue_drained", q0.size(), 0);
        chk("dut1_queue_drained", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
